pending_priority_encoder: RTL and testbench
===========================================

Name: pending_priority_encoder

Overview:
Parametrised, registered N-input priority encoder with request capture. Requests pulse into a sticky pending vector. A valid/ready output stage presents the winning index. A bit stays pending until its grant is accepted. It succeeds the fixed combinational 4-to-2 encoder and serves as the request-to-index stage in front of interrupt and service dispatch logic.

Parameters:
N, 8, number of request inputs; legal range 2..64.
IDX_W, $clog2(N), output index width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  enable; gates capture of new requests and loading of new grants
req  input  N  request pulses; bit i sets pending[i]
out_ready  input  1  consumer accepts out_idx this cycle
out_idx  output  IDX_W  granted request index
out_valid  output  1  out_idx is valid
pending  output  N  current pending vector (registered)
dropped  output  1  one-cycle pulse: a request hit an already-pending bit

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-handshake): pending=0, out_valid=0, out_idx=0, dropped=0, RR pointer=N-1.
- accept = out_valid & out_ready.
- served = one-hot(out_idx) when accept, else 0.
- pending_next = (pending & ~served) | (req & {N{en}}).
- If a new request and a clear hit the same bit in one cycle, the set wins and the bit is re-pended.
- Slot free = !out_valid | out_ready.
- On a free slot with en=1, the winner is the highest-priority bit of cand = pending & ~served:
  - if cand != 0: out_valid<=1 and out_idx<=winner.
  - if cand == 0: out_valid<=0 and out_idx holds its value.
- On a free slot with en=0: out_valid<=0. A held grant still completes its handshake while en=0.
- Stability: while out_valid & !out_ready, out_idx and out_valid stay unchanged. The held bit cannot be re-granted.
- Latency: req at edge k sets pending at edge k. With a free slot, out_valid rises at edge k+1. Back-to-back grants are issued at one per cycle.
- Fixed priority: index N-1 is highest, index 0 is lowest.
- dropped <= en & |(req & pending & ~served). It is registered and lasts exactly one cycle per event.
- pending == 0 with out_valid == 0 is the idle state. There is no other state machine.

Optional Feature:
Macro: PENDING_PE_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A pointer p (reset N-1) marks the highest-priority index.
  - On each accept of index k, p <= (k==0) ? N-1 : k-1.
  - The search runs from p downward and wraps from 0 to N-1.
- Undefined: fixed priority as above. The pointer logic is absent.

Decomposition:
- Package pending_pe_pkg:
  - clog2 function.
  - default N.
  - priority-mode constants (PRIO_FIXED, PRIO_RR).
- Sub-module prio_pick: combinational highest-set-bit finder.
  - Ports: vec[N], start[IDX_W], idx, any.
  - start is tied to N-1 in fixed mode.
  - Instantiated once.

Test Plan:
1. Reset mid-operation, N=8: pending=0x0A and out_valid=1, then pulse rst_n=0 between edges -> pending=0, out_valid=0, out_idx=0, dropped=0 immediately, before the next edge.
2. Ordered drain, N=8: req=0x0A for one cycle, out_ready=1 ->
   - out_idx=3 valid one edge later, then out_idx=1, then out_valid=0.
   - pending goes 0x0A -> 0x02 -> 0x00.
3. Backpressure, N=8: req=0x81, out_ready=0 for 5 cycles -> out_idx=7 held stable with out_valid=1. Then out_ready=1 -> grants 7 then 0, then idle.
4. Drop and enable, N=8:
   - with bit 2 pending but not yet served, req=0x04 -> dropped=1 for one cycle; pending unchanged.
   - en=0 with req=0xFF -> pending unchanged, no new grant, dropped=0.
5. Priority mode, N=8: req=0x83 held every cycle, out_ready=1 ->
   - fixed mode: grants alternate 7,1,7,1; index 0 starves.
   - PENDING_PE_ROUND_ROBIN_EN defined: grants cycle 7,1,0,7,1,0.

Source files
------------

// File: rtl/pending_pe_pkg.sv
// rtl/pending_pe_pkg.sv - shared constants and helpers for pending_priority_encoder
// Macro PENDING_PE_ROUND_ROBIN_EN selects rotating priority in the top.
package pending_pe_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational highest-set-bit finder, searching down from start
// and wrapping from 0 to N-1.
module prio_pick
  import pending_pe_pkg::*;
#(
  parameter  int N     = DEFAULT_N,
  localparam int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk from the farthest offset to the nearest so the bit closest to start wins.
  always_comb begin
    int pos;
    pos = 0;
    idx = '0;
    any = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = int'(start) - off;
      if (pos < 0) pos = pos + N;
      if (vec[pos[IDX_W-1:0]]) begin
        idx = IDX_W'(pos);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// rtl/pending_priority_encoder.sv - sticky request capture with valid/ready index output
// Macro PENDING_PE_ROUND_ROBIN_EN enables the rotating-priority pointer.
module pending_priority_encoder
  import pending_pe_pkg::*;
#(
  parameter  int N     = DEFAULT_N,
  localparam int IDX_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  output logic [N-1:0]     pending,
  output logic             dropped
);

  logic [N-1:0]     pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dropped_q, dropped_d;

  logic             accept;
  logic [N-1:0]     served;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

`ifdef PENDING_PE_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // The search begins just below the index being accepted this cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - IDX_W'(1);
  end

  assign start = ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  assign start = IDX_W'(N - 1);
`endif

  prio_pick #(.N(N)) u_pick (
    .vec   (cand),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    accept = valid_q & out_ready;
    served = '0;
    if (accept) served[idx_q] = 1'b1;
    cand      = pending_q & ~served;
    pending_d = cand | (req & {N{en}});
    dropped_d = en & (|(req & pending_q & ~served));
    valid_d   = valid_q;
    idx_d     = idx_q;
    // A held grant keeps its bit out of cand, so it can never be issued twice.
    if (!valid_q || out_ready) begin
      if (en && pick_any) begin
        valid_d = 1'b1;
        idx_d   = pick_idx;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
    end
  end

  assign pending   = pending_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// tb/tb_pending_priority_encoder.sv - self-checking bench for pending_priority_encoder
// Follows PENDING_PE_ROUND_ROBIN_EN when it is defined.
module tb_pending_priority_encoder;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [N-1:0]     req;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic [N-1:0]     pending;
  logic             dropped;

  int checks = 0;
  int errors = 0;

  pending_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .pending   (pending),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending set, current grant, drop flag, rotating pointer.
  logic [N-1:0] m_pend  = '0;
  logic         m_valid = 1'b0;
  int           m_idx   = 0;
  logic         m_drop  = 1'b0;
  int           m_ptr   = N - 1;

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] served, cand;
    int win, first;
    if (!rst_n) begin
      m_pend  <= '0;
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_drop  <= 1'b0;
      m_ptr   <= N - 1;
    end else begin
      served = '0;
      if (m_valid && out_ready) served[m_idx] = 1'b1;
      cand  = m_pend & ~served;
      win   = -1;
`ifdef PENDING_PE_ROUND_ROBIN_EN
      first = (m_valid && out_ready) ? ((m_idx == 0) ? N - 1 : m_idx - 1) : m_ptr;
      m_ptr <= first;
`else
      first = N - 1;
`endif
      for (int step = 0; step < N; step++)
        if (win < 0 && cand[(first - step + N) % N]) win = (first - step + N) % N;
      m_drop <= en && ((req & m_pend & ~served) != 0);
      m_pend <= cand | (en ? req : '0);
      if (!m_valid || out_ready) begin
        if (en && win >= 0) begin
          m_valid <= 1'b1;
          m_idx   <= win;
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_pending", pending, m_pend);
    check("cmp_valid", out_valid, m_valid);
    check("cmp_idx", out_idx, m_idx[IDX_W-1:0]);
    check("cmp_dropped", dropped, m_drop);
  end

  int exp5[4];
  int got;

  initial begin
`ifdef PENDING_PE_ROUND_ROBIN_EN
    exp5 = '{7, 1, 0, 7};
`else
    exp5 = '{7, 1, 7, 1};
`endif
    rst_n = 1'b1; en = 1'b0; req = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    check("reset_pending", pending, 0);
    check("reset_valid", out_valid, 0);
    check("reset_idx", out_idx, 0);
    check("reset_dropped", dropped, 0);

    // Ordered drain of 0x0A
    req = 8'h0A; out_ready = 1'b1;
    @(posedge clk); #2 req = '0;
    @(negedge clk);
    check("drain_pend0", pending, 8'h0A);
    check("drain_valid0", out_valid, 0);
    @(negedge clk);
    check("drain_idx3", out_idx, 3);
    check("drain_valid3", out_valid, 1);
    check("drain_pend1", pending, 8'h0A);
    @(negedge clk);
    check("drain_idx1", out_idx, 1);
    check("drain_pend2", pending, 8'h02);
    @(negedge clk);
    check("drain_idle", out_valid, 0);
    check("drain_pend3", pending, 8'h00);

    // Backpressure holds index 7
    req = 8'h81; out_ready = 1'b0;
    @(posedge clk); #2 req = '0;
    @(posedge clk); #2;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_idx7", out_idx, 7);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idx0", out_idx, 0);
    check("bp_valid0", out_valid, 1);
    @(negedge clk);
    check("bp_idle", out_valid, 0);
    check("bp_pend", pending, 0);

    // Drop on an already-pending bit, then enable gating
    req = 8'h04; out_ready = 1'b0;
    @(negedge clk);
    check("drop_none", dropped, 0);
    check("drop_pend0", pending, 8'h04);
    @(negedge clk);
    check("drop_pulse", dropped, 1);
    check("drop_pend1", pending, 8'h04);
    req = '0;
    @(negedge clk);
    check("drop_clear", dropped, 0);
    en = 1'b0; req = 8'hFF;
    @(negedge clk);
    check("en0_pend", pending, 8'h04);
    check("en0_valid", out_valid, 1);
    check("en0_idx", out_idx, 2);
    check("en0_drop", dropped, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("en0_done_pend", pending, 0);
    check("en0_done_valid", out_valid, 0);
    req = '0; en = 1'b1;

    // Priority mode with 0x83 held
    req = 8'h83;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = int'(out_idx);
      check("prio_seq", got, exp5[i]);
    end
    req = '0;
    repeat (5) @(negedge clk);
    check("prio_drain_pend", pending, 0);
    check("prio_drain_valid", out_valid, 0);

    // Asynchronous reset mid-handshake
    req = 8'h0A; out_ready = 1'b0;
    @(posedge clk); #2 req = '0;
    @(negedge clk);
    @(negedge clk);
    check("arst_pre_pend", pending, 8'h0A);
    check("arst_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pending", pending, 0);
    check("arst_valid", out_valid, 0);
    check("arst_idx", out_idx, 0);
    check("arst_dropped", dropped, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_post_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
